// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and defaults for the I2C bus arbiter.
// Holds the arbiter state encoding and the default WAIT watchdog limit.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } arb_state_e;

  localparam logic [15:0] TIMEOUT_DFLT = 16'd50000;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin winner select.
// Ports: pend (pending bits), ptr (search start) -> any, win_idx.
module rr_priority_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         pend,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] win_idx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit,
  // then map the offset back to an absolute index.
  always_comb begin
    rot = NUM_REQ'({pend, pend} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NR) sum = sum - NR;
    win_idx = sum[IW-1:0];
    any = |pend;
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one I2C_Interface between NUM_REQ requesters,
// round-robin, one byte transaction at a time, with bus lock and watchdog.
// Requester side: req/req_we/req_addr/req_wdata/lock in; gnt/done/err,
//   rdata, wsuccess, busy out.
// I2C side: i2c_start/re/we/address/we_data out; re_data/we_success/done in.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DFLT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ-1:0][7:0] req_addr,
  input  logic [NUM_REQ-1:0][7:0] req_wdata,
  input  logic [NUM_REQ-1:0]      lock,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      err,
  output logic [7:0]              rdata,
  output logic                    wsuccess,
  output logic                    busy,
  output logic                    i2c_start,
  output logic                    i2c_re,
  output logic                    i2c_we,
  output logic [7:0]              i2c_address,
  output logic [7:0]              i2c_we_data,
  input  logic [7:0]              i2c_re_data,
  input  logic                    i2c_we_success,
  input  logic                    i2c_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  arb_state_e         state, state_n;
  logic [NUM_REQ-1:0] pend, pend_n;
  logic [IW-1:0]      ptr, ptr_n;
  logic [IW-1:0]      idx, idx_n;
  logic               we_l, we_n;
  logic [7:0]         addr_l, addr_n;
  logic [7:0]         wdata_l, wdata_n;
  logic [15:0]        timer, timer_n;
  logic [NUM_REQ-1:0] done_n, err_n;
  logic [7:0]         rdata_n;
  logic               ws_n;
  logic               any, load, arb;
  logic [IW-1:0]      win;
  logic [NUM_REQ-1:0] inflight, taken;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .pend   (pend),
    .ptr    (ptr),
    .any    (any),
    .win_idx(win)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    we_n    = we_l;
    addr_n  = addr_l;
    wdata_n = wdata_l;
    timer_n = timer;
    done_n  = '0;
    err_n   = '0;
    rdata_n = rdata;
    ws_n    = wsuccess;
    load    = 1'b0;
    arb     = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          arb     = 1'b1;
          load    = 1'b1;
          idx_n   = win;
          ptr_n   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (i2c_done) begin
          done_n[idx] = 1'b1;
          if (!we_l) rdata_n = i2c_re_data;
          ws_n    = i2c_we_success;
          state_n = lock[idx] ? HOLD : IDLE;
        end else if (timer == TIMEOUT - 16'd1) begin
          done_n[idx] = 1'b1;
          err_n[idx]  = 1'b1;
          state_n     = IDLE;
        end else if (timer != 16'hFFFF) begin
          timer_n = timer + 16'd1;
        end
      end
      HOLD: begin
        // A fresh request beats a falling lock in the same cycle.
        if (req[idx]) begin
          load    = 1'b1;
          state_n = ISSUE;
        end else if (!lock[idx]) begin
          state_n = IDLE;
        end
      end
    endcase
    if (load) begin
      we_n    = req_we[idx_n];
      addr_n  = req_addr[idx_n];
      wdata_n = req_wdata[idx_n];
    end
  end

  // One outstanding transaction per requester: requests from the
  // owner or from the index being latched this cycle are dropped.
  always_comb begin
    inflight = (state != IDLE) ? (ONE << idx) : '0;
    taken    = arb ? (ONE << win) : '0;
    pend_n   = (pend | (req & ~inflight)) & ~taken;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      ptr      <= '0;
      idx      <= '0;
      we_l     <= 1'b0;
      addr_l   <= '0;
      wdata_l  <= '0;
      timer    <= '0;
      done     <= '0;
      err      <= '0;
      rdata    <= '0;
      wsuccess <= 1'b0;
    end else begin
      state    <= state_n;
      pend     <= pend_n;
      ptr      <= ptr_n;
      idx      <= idx_n;
      we_l     <= we_n;
      addr_l   <= addr_n;
      wdata_l  <= wdata_n;
      timer    <= timer_n;
      done     <= done_n;
      err      <= err_n;
      rdata    <= rdata_n;
      wsuccess <= ws_n;
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    gnt         = busy ? (ONE << idx) : '0;
    i2c_start   = (state == ISSUE);
    i2c_re      = ((state == ISSUE) || (state == WAIT)) && !we_l;
    i2c_we      = ((state == ISSUE) || (state == WAIT)) && we_l;
    i2c_address = addr_l;
    i2c_we_data = wdata_l;
  end

endmodule
